// File: rtl/mdio_phy_ctrl.sv
// PHY bring-up sequencer for mdio_master: power-up delay, a short list of
// init writes, then periodic status-register polling with link tracking.
module mdio_phy_ctrl #(
    parameter logic [4:0]  PHY_ADDR      = 5'h00,
    parameter int          INIT_DELAY    = 65535,
    parameter int          NUM_INIT      = 2,
    parameter logic [4:0]  INIT0_REG     = 5'h17,
    parameter logic [15:0] INIT0_DATA    = 16'h0022,
    parameter logic [4:0]  INIT1_REG     = 5'h00,
    parameter logic [15:0] INIT1_DATA    = 16'h1200,
    parameter logic [4:0]  STAT_REG      = 5'h01,
    parameter int          LINK_BIT      = 2,
    parameter int          POLL_INTERVAL = 4_800_000,
    parameter int          RD_TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    output logic [4:0]  cmd_phy_addr,
    output logic [4:0]  cmd_reg_addr,
    output logic [15:0] cmd_data,
    output logic [1:0]  cmd_opcode,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [15:0] data_out,
    input  logic        data_out_valid,
    output logic        data_out_ready,
    output logic        init_done,
    output logic        link_up,
    output logic        link_change,
    output logic [15:0] status_reg,
    output logic        rd_timeout
);

    localparam logic [2:0] ST_DELAY     = 3'd0;
    localparam logic [2:0] ST_INIT      = 3'd1;
    localparam logic [2:0] ST_POLL_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT   = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // One counter serves the delay, poll and timeout phases, so it is sized
    // for the largest of the three loads.
    localparam int CNT_MAX_A = (INIT_DELAY > POLL_INTERVAL) ? INIT_DELAY : POLL_INTERVAL;
    localparam int CNT_MAX   = (CNT_MAX_A > RD_TIMEOUT) ? CNT_MAX_A : RD_TIMEOUT;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          HAS_INIT = (NUM_INIT > 0);
    localparam logic          LAST_IDX = (NUM_INIT > 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          idx_q, idx_d;
    logic          init_done_q, init_done_d;
    logic          link_up_q, link_up_d;
    logic          link_change_q, link_change_d;
    logic          rd_timeout_q, rd_timeout_d;
    logic [15:0]   status_q, status_d;
    logic          cmd_fire;

    // Command fields decode straight from state so an asynchronous reset
    // withdraws cmd_valid at once and fields stay frozen under backpressure.
    always_comb begin
        cmd_valid    = 1'b0;
        cmd_reg_addr = 5'h00;
        cmd_data     = 16'h0000;
        cmd_opcode   = OP_WRITE;
        case (state_q)
            ST_INIT: begin
                cmd_valid    = 1'b1;
                cmd_reg_addr = idx_q ? INIT1_REG : INIT0_REG;
                cmd_data     = idx_q ? INIT1_DATA : INIT0_DATA;
            end
            ST_RD_ISSUE: begin
                cmd_valid    = 1'b1;
                cmd_reg_addr = STAT_REG;
                cmd_opcode   = OP_READ;
            end
            default: ;
        endcase
    end

    assign cmd_phy_addr   = PHY_ADDR;
    assign data_out_ready = (state_q == ST_RD_WAIT);
    assign cmd_fire       = cmd_valid & cmd_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        init_done_d   = init_done_q;
        link_up_d     = link_up_q;
        status_d      = status_q;
        link_change_d = 1'b0;
        rd_timeout_d  = 1'b0;
        case (state_q)
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    idx_d = 1'b0;
                    if (HAS_INIT) begin
                        state_d = ST_INIT;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = ST_RD_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_INIT: begin
                if (cmd_fire) begin
                    if (idx_q == LAST_IDX) begin
                        init_done_d = 1'b1;
                        state_d     = ST_RD_ISSUE;
                    end else begin
                        idx_d = 1'b1;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (cmd_fire) begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = CW'(RD_TIMEOUT);
                end
            end
            ST_RD_WAIT: begin
                // Data arriving on the final wait cycle beats the timeout.
                if (data_out_valid) begin
                    status_d      = data_out;
                    link_up_d     = data_out[LINK_BIT];
                    link_change_d = data_out[LINK_BIT] ^ link_up_q;
                    state_d       = ST_POLL_WAIT;
                    cnt_d         = CW'(POLL_INTERVAL);
                end else if (cnt_q <= CNT_ONE) begin
                    rd_timeout_d  = 1'b1;
                    link_up_d     = 1'b0;
                    link_change_d = link_up_q;
                    state_d       = ST_POLL_WAIT;
                    cnt_d         = CW'(POLL_INTERVAL);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_POLL_WAIT: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RD_ISSUE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_DELAY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_DELAY;
            cnt_q         <= CW'(INIT_DELAY);
            idx_q         <= 1'b0;
            init_done_q   <= 1'b0;
            link_up_q     <= 1'b0;
            link_change_q <= 1'b0;
            rd_timeout_q  <= 1'b0;
            status_q      <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            init_done_q   <= init_done_d;
            link_up_q     <= link_up_d;
            link_change_q <= link_change_d;
            rd_timeout_q  <= rd_timeout_d;
            status_q      <= status_d;
        end
    end

    assign init_done   = init_done_q;
    assign link_up     = link_up_q;
    assign link_change = link_change_q;
    assign rd_timeout  = rd_timeout_q;
    assign status_reg  = status_q;

endmodule
